// File: rtl/divider.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed latency: start accepted at E0, 32 iterations, result and done pulse registered at E33.
module divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] x_q, x_d;
  logic            is_rem_q, is_rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] out_q, out_d;

  logic            is_signed, x_neg, y_neg, fits;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] q_res, r_res;

  assign is_signed = ~op[0];
  assign x_neg     = is_signed & x[XLEN-1];
  assign y_neg     = is_signed & y[XLEN-1];

  // One restoring step: bring in the next dividend bit and trial-subtract.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[XLEN];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      x_q      <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      x_q      <= x_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    x_d      = x_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    out_d    = out_q;
    q_res    = qneg_q ? -quo_q : quo_q;
    r_res    = rneg_q ? -rem_q : rem_q;

    // Special cases take priority over the iterated result.
    if (dz_q) begin
      q_res = '1;
      r_res = x_q;
    end else if (ovf_q) begin
      q_res = INT_MIN;
      r_res = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = x_neg ? -x : x;
          dvs_d    = y_neg ? -y : y;
          x_d      = x;
          is_rem_d = op[1];
          qneg_d   = x_neg ^ y_neg;
          rneg_d   = x_neg;
          dz_d     = (y == '0);
          ovf_d    = is_signed && (x == INT_MIN) && (y == '1);
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        rem_d = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], fits};
        cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        out_d  = is_rem_q ? r_res : q_res;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
